except_commit_arbiter: RTL and testbench

Multi-lane commit-stage exception arbiter for the writeback/commit boundary. Each lane carries an instruction and any exception raised upstream. The block re-examines each lane's instruction for late exceptions under the current privilege level and selects the oldest excepting lane. It registers the commit mask and holds a trap request to the CSR/trap unit under a valid/ready handshake, then pulses a pipeline flush once the trap is accepted.

---
 rtl/except_commit_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_except_commit_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/except_commit_arbiter.sv
// Commit-stage exception arbiter: late-checks each lane, picks the oldest excepting lane, raises a trap request.
// Latency: commit_valid/commit_mask/trap_valid registered one cycle after group acceptance; flush one cycle after trap accept.
// Backpressure: in_ready is low while a trap is pending or flushing; trap_valid is held with a stable payload until trap_ready.
module except_commit_arbiter #(
   parameter int LANES = 2,
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES-1:0]      lane_valid,
   input  logic [LANES*XLEN-1:0] lane_pc,
   input  logic [LANES*32-1:0]   lane_inst,
   input  logic [LANES-1:0]      lane_exc,
   input  logic [LANES*XLEN-1:0] lane_ecause,
   input  logic [LANES*XLEN-1:0] lane_etval,
   input  logic [1:0]            priv,
   output logic                  commit_valid,
   output logic [LANES-1:0]      commit_mask,
   output logic                  trap_valid,
   input  logic                  trap_ready,
   output logic [XLEN-1:0]       trap_epc,
   output logic [XLEN-1:0]       trap_ecause,
   output logic [XLEN-1:0]       trap_etval,
   output logic                  flush,
   output logic [CNT_W-1:0]      trap_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAP  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   state_t            state_q, state_d;
   logic              commit_valid_q, commit_valid_d;
   logic [LANES-1:0]  commit_mask_q, commit_mask_d;
   logic              trap_valid_q, trap_valid_d;
   logic              flush_q, flush_d;
   logic [CNT_W-1:0]  trap_count_q, trap_count_d;
   logic [XLEN-1:0]   trap_epc_q, trap_epc_d;
   logic [XLEN-1:0]   trap_ecause_q, trap_ecause_d;
   logic [XLEN-1:0]   trap_etval_q, trap_etval_d;

   // per-lane scratch for the arbitration loop
   logic [XLEN-1:0]   cur_pc;
   logic [31:0]       cur_inst;
   logic              cur_hit;
   logic [XLEN-1:0]   cur_cause;
   logic [XLEN-1:0]   cur_tval;

   // arbitration result for the group currently on the inputs
   logic              any_exc;
   logic [LANES-1:0]  grp_mask;
   logic [XLEN-1:0]   win_pc;
   logic [XLEN-1:0]   win_cause;
   logic [XLEN-1:0]   win_tval;

   // Ready depends on state only so the producer never sees a loop through in_valid.
   assign in_ready = (state_q == ST_IDLE);

   // Late exception check per lane and oldest-lane winner selection; lanes from the winner upward never retire.
   always_comb begin
      any_exc   = 1'b0;
      grp_mask  = '0;
      win_pc    = '0;
      win_cause = '0;
      win_tval  = '0;
      cur_pc    = '0;
      cur_inst  = '0;
      cur_hit   = 1'b0;
      cur_cause = '0;
      cur_tval  = '0;
      for (int i = 0; i < LANES; i++) begin
         cur_pc    = lane_pc[i*XLEN +: XLEN];
         cur_inst  = lane_inst[i*32 +: 32];
         cur_hit   = 1'b1;
         cur_cause = '0;
         cur_tval  = '0;
         if (lane_exc[i]) begin
            // upstream exception is authoritative and passes through untouched
            cur_cause = lane_ecause[i*XLEN +: XLEN];
            cur_tval  = lane_etval[i*XLEN +: XLEN];
         end else if (cur_pc[1:0] != 2'b00) begin
            cur_cause = XLEN'(0);
            cur_tval  = cur_pc;
         end else if ((cur_inst == 32'h0) || (cur_inst[1:0] != 2'b11)) begin
            cur_cause = XLEN'(2);
            cur_tval  = XLEN'(cur_inst);
         end else if (cur_inst == INST_ECALL) begin
            cur_cause = XLEN'(8) + XLEN'(priv);
         end else if (cur_inst == INST_EBREAK) begin
            cur_cause = XLEN'(3);
            cur_tval  = cur_pc;
         end else begin
            cur_hit = 1'b0;
         end
         cur_hit = cur_hit & lane_valid[i];
         if (!any_exc && cur_hit) begin
            any_exc   = 1'b1;
            win_pc    = cur_pc;
            win_cause = cur_cause;
            win_tval  = cur_tval;
         end
         grp_mask[i] = lane_valid[i] & ~any_exc;
      end
   end

   // Next-state and registered-output computation for IDLE -> TRAP -> FLUSH.
   always_comb begin
      state_d        = state_q;
      commit_valid_d = 1'b0;
      commit_mask_d  = '0;
      trap_valid_d   = trap_valid_q;
      flush_d        = 1'b0;
      trap_count_d   = trap_count_q;
      trap_epc_d     = trap_epc_q;
      trap_ecause_d  = trap_ecause_q;
      trap_etval_d   = trap_etval_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               commit_valid_d = 1'b1;
               commit_mask_d  = grp_mask;
               if (any_exc) begin
                  trap_valid_d  = 1'b1;
                  trap_epc_d    = win_pc;
                  trap_ecause_d = win_cause;
                  trap_etval_d  = win_tval;
                  state_d       = ST_TRAP;
               end
            end
         end
         ST_TRAP: begin
            if (trap_ready) begin
               trap_valid_d = 1'b0;
               flush_d      = 1'b1;
               state_d      = ST_FLUSH;
               if (trap_count_q != {CNT_W{1'b1}}) begin
                  trap_count_d = trap_count_q + CNT_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            trap_valid_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: begin
            trap_valid_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // State and output registers; async reset drops everything to idle immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= ST_IDLE;
         commit_valid_q <= 1'b0;
         commit_mask_q  <= '0;
         trap_valid_q   <= 1'b0;
         flush_q        <= 1'b0;
         trap_count_q   <= '0;
         trap_epc_q     <= '0;
         trap_ecause_q  <= '0;
         trap_etval_q   <= '0;
      end else begin
         state_q        <= state_d;
         commit_valid_q <= commit_valid_d;
         commit_mask_q  <= commit_mask_d;
         trap_valid_q   <= trap_valid_d;
         flush_q        <= flush_d;
         trap_count_q   <= trap_count_d;
         trap_epc_q     <= trap_epc_d;
         trap_ecause_q  <= trap_ecause_d;
         trap_etval_q   <= trap_etval_d;
      end
   end

   assign commit_valid = commit_valid_q;
   assign commit_mask  = commit_mask_q;
   assign trap_valid   = trap_valid_q;
   assign flush        = flush_q;
   assign trap_count   = trap_count_q;
   assign trap_epc     = trap_epc_q;
   assign trap_ecause  = trap_ecause_q;
   assign trap_etval   = trap_etval_q;

endmodule

// File: tb/tb_except_commit_arbiter.sv
// Bench for except_commit_arbiter: directed steps then randomized groups against a reference model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: trap_ready held low for a chosen number of cycles before acceptance.
module tb_except_commit_arbiter;

   localparam int LANES = 2;
   localparam int XLEN  = 64;
   localparam int CNT_W = 2;

   logic                   clk;
   logic                   rstn;
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES-1:0]       lane_valid;
   logic [1:0][XLEN-1:0]   pcs;
   logic [1:0][31:0]       insts;
   logic [LANES-1:0]       lane_exc;
   logic [1:0][XLEN-1:0]   ecs;
   logic [1:0][XLEN-1:0]   etvs;
   logic [1:0]             priv;
   logic                   commit_valid;
   logic [LANES-1:0]       commit_mask;
   logic                   trap_valid;
   logic                   trap_ready;
   logic [XLEN-1:0]        trap_epc;
   logic [XLEN-1:0]        trap_ecause;
   logic [XLEN-1:0]        trap_etval;
   logic                   flush;
   logic [CNT_W-1:0]       trap_count;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   typedef struct packed {
      logic [1:0]  mask;
      logic        trap;
      logic [63:0] epc;
      logic [63:0] cause;
      logic [63:0] tval;
   } exp_t;

   except_commit_arbiter #(.LANES(LANES), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .lane_valid(lane_valid), .lane_pc(pcs), .lane_inst(insts),
      .lane_exc(lane_exc), .lane_ecause(ecs), .lane_etval(etvs),
      .priv(priv),
      .commit_valid(commit_valid), .commit_mask(commit_mask),
      .trap_valid(trap_valid), .trap_ready(trap_ready),
      .trap_epc(trap_epc), .trap_ecause(trap_ecause), .trap_etval(trap_etval),
      .flush(flush), .trap_count(trap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Architectural late-exception rules for one lane, in priority order.
   function automatic void late_rule(input logic [63:0] pc, input logic [31:0] inst, input logic [1:0] p,
                                     output bit hit, output logic [63:0] c, output logic [63:0] t);
      hit = 1'b1;
      c   = 64'd0;
      t   = 64'd0;
      if (pc % 4 != 0) begin
         t = pc;
      end else if (inst == 32'd0 || inst % 4 != 3) begin
         c = 64'd2;
         t = {32'd0, inst};
      end else if (inst == 32'h0000_0073) begin
         c = 64'd8 + 64'(p);
      end else if (inst == 32'h0010_0073) begin
         c = 64'd3;
         t = pc;
      end else begin
         hit = 1'b0;
      end
   endfunction

   // Expected outcome of the group currently driven on the inputs.
   function automatic exp_t model();
      exp_t        e;
      int          w;
      bit          hit;
      logic [63:0] c, t;
      e = '0;
      w = -1;
      for (int i = 0; i < LANES; i++) begin
         if (w < 0 && lane_valid[i]) begin
            if (lane_exc[i]) begin
               hit = 1'b1;
               c   = ecs[i];
               t   = etvs[i];
            end else begin
               late_rule(pcs[i], insts[i], priv, hit, c, t);
            end
            if (hit) begin
               w       = i;
               e.epc   = pcs[i];
               e.cause = c;
               e.tval  = t;
            end
         end
      end
      e.trap = (w >= 0);
      if (e.trap) e.mask = 2'(int'(lane_valid) & ((1 << w) - 1));
      else        e.mask = lane_valid;
      return e;
   endfunction

   task automatic set_lane(input int i, input bit v, input logic [63:0] pc, input logic [31:0] inst,
                           input bit exc, input logic [63:0] c, input logic [63:0] t);
      lane_valid[i] = v;
      pcs[i]        = pc;
      insts[i]      = inst;
      lane_exc[i]   = exc;
      ecs[i]        = c;
      etvs[i]       = t;
   endtask

   // Offer one group, check the registered result, then drive the trap handshake after 'hold' stalled cycles.
   task automatic do_group(input string tag, input int hold);
      exp_t e;
      e = model();
      chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, ".commit_valid"}, 64'(commit_valid), 64'd1);
      chk({tag, ".commit_mask"}, 64'(commit_mask), 64'(e.mask));
      chk({tag, ".trap_valid"}, 64'(trap_valid), 64'(e.trap));
      chk({tag, ".flush_low"}, 64'(flush), 64'd0);
      if (e.trap) begin
         chk({tag, ".epc"}, trap_epc, e.epc);
         chk({tag, ".cause"}, trap_ecause, e.cause);
         chk({tag, ".tval"}, trap_etval, e.tval);
         chk({tag, ".in_ready_trap"}, 64'(in_ready), 64'd0);
         for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, ".stall_commit_valid"}, 64'(commit_valid), 64'd0);
            chk({tag, ".stall_trap_valid"}, 64'(trap_valid), 64'd1);
            chk({tag, ".stall_epc"}, trap_epc, e.epc);
            chk({tag, ".stall_cause"}, trap_ecause, e.cause);
            chk({tag, ".stall_in_ready"}, 64'(in_ready), 64'd0);
         end
         in_valid   = 1'b0;
         trap_ready = 1'b1;
         @(posedge clk); #1;
         trap_ready = 1'b0;
         exp_cnt = (exp_cnt >= 3) ? 3 : exp_cnt + 1;
         chk({tag, ".flush_high"}, 64'(flush), 64'd1);
         chk({tag, ".trap_dropped"}, 64'(trap_valid), 64'd0);
         chk({tag, ".in_ready_flush"}, 64'(in_ready), 64'd0);
         chk({tag, ".trap_count"}, 64'(trap_count), 64'(exp_cnt));
         @(posedge clk); #1;
         chk({tag, ".flush_done"}, 64'(flush), 64'd0);
         chk({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
      end else begin
         trap_ready = 1'b1;
         @(posedge clk); #1;
         trap_ready = 1'b0;
         chk({tag, ".commit_valid_pulse"}, 64'(commit_valid), 64'd0);
         chk({tag, ".no_flush"}, 64'(flush), 64'd0);
         chk({tag, ".count_unchanged"}, 64'(trap_count), 64'(exp_cnt));
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".commit_valid"}, 64'(commit_valid), 64'd0);
      chk({tag, ".commit_mask"}, 64'(commit_mask), 64'd0);
      chk({tag, ".trap_valid"}, 64'(trap_valid), 64'd0);
      chk({tag, ".flush"}, 64'(flush), 64'd0);
      chk({tag, ".trap_count"}, 64'(trap_count), 64'd0);
      chk({tag, ".epc"}, trap_epc, 64'd0);
      chk({tag, ".cause"}, trap_ecause, 64'd0);
      chk({tag, ".tval"}, trap_etval, 64'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
      exp_cnt = 0;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick_inst(input int kind);
      logic [31:0] r;
      r = $urandom;
      case (kind)
         0: return 32'h00b5_0533;
         1: return 32'h0;
         2: return {r[31:2], 2'b01};
         3: return 32'h0000_0073;
         4: return 32'h0010_0073;
         default: return {r[31:2], 2'b11};
      endcase
   endfunction

   initial begin
      rstn       = 1'b1;
      in_valid   = 1'b0;
      trap_ready = 1'b0;
      lane_valid = '0;
      pcs        = '0;
      insts      = '0;
      lane_exc   = '0;
      ecs        = '0;
      etvs       = '0;
      priv       = 2'd3;
      #2 rstn = 1'b0;
      #1;
      check_reset_values("reset");
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("reset.in_ready", 64'(in_ready), 64'd1);

      // clean two-lane group
      priv = 2'd3;
      set_lane(0, 1, 64'h1000, 32'h00b5_0533, 0, 0, 0);
      set_lane(1, 1, 64'h1004, 32'h00b5_0533, 0, 0, 0);
      do_group("clean", 0);

      // ecall in lane 1 from user mode, trap stalled three cycles
      priv = 2'd0;
      set_lane(0, 1, 64'h1000, 32'h00b5_0533, 0, 0, 0);
      set_lane(1, 1, 64'h1004, 32'h0000_0073, 0, 0, 0);
      do_group("ecall_u", 3);

      // upstream exception in lane 0 beats misaligned lane 1
      priv = 2'd3;
      set_lane(0, 1, 64'h1000, 32'h00b5_0533, 1, 64'd13, 64'hdead);
      set_lane(1, 1, 64'h1002, 32'h00b5_0533, 0, 0, 0);
      do_group("upstream", 1);

      // zero instruction, then misaligned PC taking precedence over it
      set_lane(0, 1, 64'h2000, 32'h0, 0, 0, 0);
      set_lane(1, 0, 64'h2004, 32'h0, 0, 0, 0);
      do_group("inst_zero", 0);
      set_lane(0, 1, 64'h2002, 32'h0, 0, 0, 0);
      do_group("misalign", 2);

      // ebreak and empty group
      set_lane(0, 1, 64'h3000, 32'h0010_0073, 0, 0, 0);
      set_lane(1, 1, 64'h3004, 32'h00b5_0533, 0, 0, 0);
      do_group("ebreak", 0);
      set_lane(0, 0, 64'h3002, 32'h0, 1, 64'd5, 64'd5);
      set_lane(1, 0, 64'h3006, 32'h0, 0, 0, 0);
      do_group("empty", 0);

      // randomized groups
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 2))
            0: priv = 2'd0;
            1: priv = 2'd1;
            default: priv = 2'd3;
         endcase
         for (int i = 0; i < LANES; i++) begin
            logic [63:0] pc;
            pc = {$urandom, $urandom & 32'hffff_fffc};
            if ($urandom_range(0, 5) == 0) pc[1] = 1'b1;
            set_lane(i, ($urandom_range(0, 4) != 0), pc, pick_inst($urandom_range(0, 7)),
                     ($urandom_range(0, 7) == 0), {$urandom, $urandom}, {$urandom, $urandom});
         end
         do_group("rand", $urandom_range(0, 3));
      end

      // trap counter saturation from a fresh reset: 1,2,3,3,3
      pulse_reset();
      priv = 2'd1;
      for (int n = 0; n < 5; n++) begin
         set_lane(0, 1, 64'h4000 + 64'(n * 8), 32'h0000_0073, 0, 0, 0);
         set_lane(1, 1, 64'h4004, 32'h00b5_0533, 0, 0, 0);
         do_group("saturate", n % 2);
      end

      // reset in the middle of a pending trap
      set_lane(0, 1, 64'h5000, 32'h0, 0, 0, 0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("midtrap.trap_valid", 64'(trap_valid), 64'd1);
      #2 rstn = 1'b0;
      #1;
      exp_cnt = 0;
      check_reset_values("midtrap");
      chk("midtrap.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("postreset.flush", 64'(flush), 64'd0);
      set_lane(0, 1, 64'h6000, 32'h00b5_0533, 0, 0, 0);
      set_lane(1, 1, 64'h6004, 32'h00b5_0533, 0, 0, 0);
      do_group("postreset", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
